card_cycle_ctrl: RTL

//  Sequencer for the punched-card reader feeding the es24 counter. Runs the card-cycle clock:

---
 rtl/card_cycle_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/card_cycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : card_cycle_ctrl
//  Description : Card-cycle sequencer for the punched-card reader feeding es24.
//                Optional total/clear cycle enabled by CARD_CYCLE_TOTAL_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module card_cycle_ctrl #(
    parameter int ROW_CYCLES   = 128,
    parameter int PULSE_CYCLES = 64,
    parameter int GAP_CYCLES   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        hopper_empty,
    output logic        feed_req,
    input  logic        feed_ack,
    output logic [12:0] timing,
    output logic [3:0]  row,
    output logic        brush1_valid,
    output logic        brush2_valid,
    output logic        card_shift,
    output logic        busy,
    output logic        done,
    output logic        total_pulse
);

    localparam int c_CNT_MAX = (ROW_CYCLES > GAP_CYCLES) ? ROW_CYCLES : GAP_CYCLES;
    localparam int c_CW      = $clog2(c_CNT_MAX);

    localparam logic [c_CW-1:0] c_ROW_LAST  = c_CW'(ROW_CYCLES - 1);
    localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(GAP_CYCLES - 1);
    localparam logic [c_CW:0]   c_PULSE     = (c_CW + 1)'(PULSE_CYCLES);
    localparam logic [3:0]      c_LAST_SLOT = 4'd11;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FEED  = 3'd1;
    localparam logic [2:0] c_ST_ROWS  = 3'd2;
    localparam logic [2:0] c_ST_GAP   = 3'd3;
    localparam logic [2:0] c_ST_SHIFT = 3'd4;
`ifdef CARD_CYCLE_TOTAL_EN
    localparam logic [2:0] c_ST_TOTAL = 3'd5;
`endif

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_CW-1:0] r_cyc;
    logic [3:0]      r_slot;
    logic            r_feed_entry;
    logic            r_stop_latched;
    logic            r_b1;
    logic            r_b2;
    logic            r_done;
`ifdef CARD_CYCLE_TOTAL_EN
    logic            r_total_run;
`endif

    logic w_rows_active;
    logic w_slot_end;
    logic w_gap_end;
    logic w_in_pulse;
    logic w_can_feed;
    logic w_cards;
    logic w_feeding;
    logic w_load_b1;
    logic w_done_nxt;

`ifdef CARD_CYCLE_TOTAL_EN
    assign w_rows_active = (r_state == c_ST_ROWS) || (r_state == c_ST_TOTAL);
`else
    assign w_rows_active = (r_state == c_ST_ROWS);
`endif
    assign w_slot_end = (r_cyc == c_ROW_LAST);
    assign w_gap_end  = (r_cyc == c_GAP_LAST);
    assign w_in_pulse = ({1'b0, r_cyc} < c_PULSE);
    assign w_can_feed = !hopper_empty && !r_stop_latched;
    assign w_cards    = r_b1 || r_b2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The FEED entry cycle decides the branch; later FEED cycles are only the ack wait.
    always_comb begin
        w_state_nxt = r_state;
        w_load_b1   = 1'b0;
        w_done_nxt  = 1'b0;
        w_feeding   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_state_nxt = c_ST_FEED;
            end
            c_ST_FEED: begin
                if (!r_feed_entry || w_can_feed) begin
                    w_feeding = 1'b1;
                    if (feed_ack) begin
                        w_load_b1   = 1'b1;
                        w_state_nxt = c_ST_ROWS;
                    end
                end else if (r_stop_latched && w_cards) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_b2) begin
                    w_state_nxt = c_ST_ROWS;
                end else begin
`ifdef CARD_CYCLE_TOTAL_EN
                    w_state_nxt = c_ST_TOTAL;
`else
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end
            end
            c_ST_ROWS: begin
                if (w_slot_end && (r_slot == c_LAST_SLOT)) w_state_nxt = c_ST_GAP;
            end
`ifdef CARD_CYCLE_TOTAL_EN
            c_ST_TOTAL: begin
                if (w_slot_end && (r_slot == c_LAST_SLOT)) w_state_nxt = c_ST_GAP;
            end
`endif
            c_ST_GAP: begin
                if (w_gap_end) begin
`ifdef CARD_CYCLE_TOTAL_EN
                    if (r_total_run) begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_SHIFT;
                    end
`else
                    w_state_nxt = c_ST_SHIFT;
`endif
                end
            end
            c_ST_SHIFT: begin
                w_state_nxt = c_ST_FEED;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc          <= '0;
            r_slot         <= '0;
            r_feed_entry   <= 1'b0;
            r_stop_latched <= 1'b0;
            r_b1           <= 1'b0;
            r_b2           <= 1'b0;
            r_done         <= 1'b0;
`ifdef CARD_CYCLE_TOTAL_EN
            r_total_run    <= 1'b0;
`endif
        end else begin
            r_done       <= w_done_nxt;
            r_feed_entry <= (w_state_nxt == c_ST_FEED) && (r_state != c_ST_FEED);

            if ((r_state == c_ST_IDLE) && start) begin
                r_stop_latched <= 1'b0;
            end else if ((r_state != c_ST_IDLE) && stop) begin
                r_stop_latched <= 1'b1;
            end

            if (w_rows_active) begin
                if (w_slot_end) begin
                    r_cyc  <= '0;
                    r_slot <= (r_slot == c_LAST_SLOT) ? 4'd0 : r_slot + 4'd1;
                end else begin
                    r_cyc <= r_cyc + 1'b1;
                end
            end else if (r_state == c_ST_GAP) begin
                r_cyc  <= w_gap_end ? '0 : r_cyc + 1'b1;
                r_slot <= '0;
            end else begin
                r_cyc  <= '0;
                r_slot <= '0;
            end

            if (w_load_b1) begin
                r_b1 <= 1'b1;
            end else if (r_state == c_ST_SHIFT) begin
                r_b2 <= r_b1;
                r_b1 <= 1'b0;
            end

`ifdef CARD_CYCLE_TOTAL_EN
            // Remembers through GAP that this cycle carried no card, so GAP ends in IDLE.
            if (r_state == c_ST_TOTAL) begin
                r_total_run <= 1'b1;
            end else if (r_state != c_ST_GAP) begin
                r_total_run <= 1'b0;
            end
`endif
        end
    end

    always_comb begin
        timing       = '0;
        row          = '0;
        feed_req     = w_feeding;
        brush1_valid = r_b1;
        brush2_valid = r_b2;
        card_shift   = (r_state == c_ST_SHIFT);
        busy         = (r_state != c_ST_IDLE);
        done         = r_done;
        total_pulse  = 1'b0;
        if (w_rows_active) begin
            row = r_slot;
            if (w_in_pulse) begin
                if (r_slot < 4'd10) begin
                    timing[4'd9 - r_slot] = 1'b1;
                end else if (r_slot == 4'd10) begin
                    timing[11] = 1'b1;
                end else begin
                    timing[12] = 1'b1;
                end
            end
        end
`ifdef CARD_CYCLE_TOTAL_EN
        total_pulse = (r_state == c_ST_TOTAL) && (r_slot == c_LAST_SLOT) && w_in_pulse;
`endif
    end

endmodule
`default_nettype wire
